// File: rtl/wb_regfile.sv
// wb_regfile: four-entry write-back register file with a one-deep pending write stage and read bypass.
module wb_regfile #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] rd_addr_a,
    input  logic [$clog2(NREG)-1:0] rd_addr_b,
    output logic [WIDTH-1:0]        rd_data_a,
    output logic [WIDTH-1:0]        rd_data_b,
    output logic                    pend_valid,
    output logic [7:0]              wr_count
);
    localparam int AW = $clog2(NREG);
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             pv_q, pv_d;
    logic [AW-1:0]    pa_q, pa_d;
    logic [WIDTH-1:0] pd_q, pd_d;
    logic [7:0]       cnt_q, cnt_d;
    always_comb begin
        regs_d = regs_q;
        if (pv_q) regs_d[pa_q] = pd_q;
        pv_d  = wb_en;
        pa_d  = wb_en ? wb_addr : pa_q;
        pd_d  = wb_en ? wb_data : pd_q;
        cnt_d = cnt_q + 8'(pv_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
            pv_q   <= 1'b0;
            pa_q   <= '0;
            pd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pv_q   <= pv_d;
            pa_q   <= pa_d;
            pd_q   <= pd_d;
            cnt_q  <= cnt_d;
        end
    end
    // The pending write is already architecturally visible, so it shadows the array.
    assign rd_data_a  = (pv_q && pa_q == rd_addr_a) ? pd_q : regs_q[rd_addr_a];
    assign rd_data_b  = (pv_q && pa_q == rd_addr_b) ? pd_q : regs_q[rd_addr_b];
    assign pend_valid = pv_q;
    assign wr_count   = cnt_q;
endmodule
